// File: rtl/pc_pkg.sv
// Shared constants for the PC fetch stage: FSM encoding, IM address width, default reset PC.
package pc_pkg;

  localparam int unsigned IM_AW = 10;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_HALT  = 2'b01,
    ST_FAULT = 2'b10
  } state_e;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC target computation, priority select (jr > jump > branch > seq) and legality flag.
module pc_next_sel
  import pc_pkg::*;
#(
  parameter int unsigned IM_WORDS = 32
) (
  input  logic [31:0] pc,
  input  logic        branch_taken,
  input  logic        jump,
  input  logic        jr,
  input  logic [15:0] imm16,
  input  logic [25:0] target26,
  input  logic [31:0] rs_data,
  output logic [31:0] pc_plus4_c,
  output logic [31:0] target_c,
  output logic        legal_c
);

  // One past the last legal byte address; 33 bits so a full 4 GiB range cannot overflow.
  localparam logic [32:0] PC_LIMIT = 33'(IM_WORDS) << 2;

  logic [31:0] br_c;
  logic [31:0] jmp_c;

  assign pc_plus4_c = pc + 32'd4;
  assign br_c       = pc_plus4_c + {{14{imm16[15]}}, imm16, 2'b00};
  assign jmp_c      = {pc_plus4_c[31:28], target26, 2'b00};

  always_comb begin
    target_c = pc_plus4_c;
    if (jr)                target_c = rs_data;
    else if (jump)         target_c = jmp_c;
    else if (branch_taken) target_c = br_c;
  end

  assign legal_c = (target_c[1:0] == 2'b00) && ({1'b0, target_c} < PC_LIMIT);

endmodule

// File: rtl/pc_fetch_ctrl.sv
// PC register and run/halt/fault FSM of the fetch stage.
// Optional PC_PERF_CNT_EN adds saturating retired/redirect counters.
module pc_fetch_ctrl
  import pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter int unsigned IM_WORDS = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             halt_req,
  input  logic             branch_taken,
  input  logic             jump,
  input  logic             jr,
  input  logic [15:0]      imm16,
  input  logic [25:0]      target26,
  input  logic [31:0]      rs_data,
  output logic [31:0]      pc,
  output logic [31:0]      pc_plus4,
  output logic [IM_AW-1:0] PCaddr,
`ifdef PC_PERF_CNT_EN
  output logic [31:0]      retired_cnt,
  output logic [31:0]      redirect_cnt,
`endif
  output logic [1:0]       state,
  output logic             fault
);

  state_e      state_q;
  logic [31:0] target_c;
  logic        legal_c;

  pc_next_sel #(
    .IM_WORDS(IM_WORDS)
  ) u_next_sel (
    .pc          (pc),
    .branch_taken(branch_taken),
    .jump        (jump),
    .jr          (jr),
    .imm16       (imm16),
    .target26    (target26),
    .rs_data     (rs_data),
    .pc_plus4_c  (pc_plus4),
    .target_c    (target_c),
    .legal_c     (legal_c)
  );

  assign state  = state_q;
  assign PCaddr = pc[IM_AW+1:2];

  // PC register and FSM; an illegal target freezes pc and latches FAULT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc      <= RESET_PC;
      state_q <= ST_RUN;
      fault   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (halt_req) begin
            state_q <= ST_HALT;
          end else if (!stall) begin
            if (legal_c) begin
              pc <= target_c;
            end else begin
              state_q <= ST_FAULT;
              fault   <= 1'b1;
            end
          end
        end
        ST_HALT, ST_FAULT: begin
        end
        default: begin
          state_q <= ST_FAULT;
          fault   <= 1'b1;
        end
      endcase
    end
  end

`ifdef PC_PERF_CNT_EN
  logic upd_c;
  logic redir_c;

  assign upd_c   = (state_q == ST_RUN) && !halt_req && !stall && legal_c;
  assign redir_c = jr | jump | branch_taken;

  // Saturating event counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_cnt  <= 32'd0;
      redirect_cnt <= 32'd0;
    end else if (upd_c) begin
      if (retired_cnt != 32'hFFFF_FFFF) retired_cnt <= retired_cnt + 32'd1;
      if (redir_c && (redirect_cnt != 32'hFFFF_FFFF)) redirect_cnt <= redirect_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pc_fetch_ctrl.md
Name: pc_fetch_ctrl

Overview:
- Program-counter and next-PC stage of the single-cycle CPU.
- Sits directly upstream of the instruction memory and drives its 10-bit word address every cycle.
- Selects the next PC from the following sources: sequential, taken branch, jump, or jump-register.
- Owns a small run/halt/fault state machine, so the fetch stream can be frozen cleanly.

Parameters:
- RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset; must be word-aligned.
- IM_WORDS, 32, number of valid instruction-memory words; the legal PC range is [0, IM_WORDS*4).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- stall  input  1  hold the PC this cycle
- halt_req  input  1  request a permanent halt (e.g. decode of a halt/syscall instruction)
- branch_taken  input  1  conditional branch resolved taken
- jump  input  1  J/JAL-type jump
- jr  input  1  jump-register
- imm16  input  16  branch offset in words, signed
- target26  input  26  jump target field
- rs_data  input  32  register value for jr
- pc  output  32  current PC, byte address
- pc_plus4  output  32  pc + 4, combinational (link value)
- PCaddr  output  10  word address to instruction memory, equal to pc[11:2]
- state  output  2  00 RUN, 01 HALT, 10 FAULT
- fault  output  1  high while in FAULT

Behaviour:
- Reset (asynchronous, any time, including mid-redirect):
  - pc = RESET_PC, state = RUN, fault = 0.
  - PCaddr = RESET_PC[11:2].
  - Deasserting rst resumes fetch at the next rising edge.
- Target computation (all arithmetic 32-bit, wraps mod 2^32 before range check):
  - seq = pc + 4
  - br = pc + 4 + (sign-extend(imm16) << 2)
  - jmp = {pc_plus4[31:28], target26, 2'b00}
  - jrt = rs_data
- Next-PC priority, evaluated only in RUN:
  - halt_req > stall > jr > jump > branch_taken > seq
- Legality check on the selected target (not applied on stall or halt):
  - A target is illegal if target[1:0] != 0, or target >= IM_WORDS*4.
  - On an illegal target: pc is not updated, the FSM goes to FAULT, fault = 1 from the next cycle.
- Latency and output timing:
  - One cycle. The selected legal target appears on pc/PCaddr after the next rising edge.
  - PCaddr and pc are registered; pc_plus4 is combinational from pc.
- FSM states and transitions:
  - RUN → HALT on halt_req, regardless of stall. pc holds at the value of the halting instruction.
  - RUN → FAULT on an illegal target.
  - HALT and FAULT are sticky. All inputs are ignored; pc holds. Only rst exits.
- Boundary conditions:
  - Last word: pc = IM_WORDS*4-4 with seq selected → FAULT; there is no silent wrap to 0.
  - Zero-offset branch: branch_taken with imm16 = 16'hFFFF targets pc itself (a legal self-loop).
  - Simultaneous stall and jump: stall wins; the jump is lost unless it is re-asserted the next cycle (the upstream holds it during stall).
  - PCaddr upper bits: PCaddr always equals pc[11:2]; bits above 11 are checked only via the IM_WORDS range rule.

Optional Feature:
- Macro: PC_PERF_CNT_EN.
- When defined, adds these outputs:
  - retired_cnt (32): increments each cycle pc updates in RUN.
  - redirect_cnt (32): increments when that update came from jr, jump, or branch.
- Both counters reset to 0 on rst and saturate at 32'hFFFF_FFFF.
- When undefined, the ports and logic are absent, and the rest of the behaviour is identical.

Decomposition:
- Shared package pc_pkg holds:
  - state encoding constants ST_RUN = 2'b00, ST_HALT = 2'b01, ST_FAULT = 2'b10
  - IM address width (10)
  - the default RESET_PC
- One natural sub-module: pc_next_sel.
  - Purely combinational.
  - Computes the four targets, priority-selects one, and produces the legal flag.
  - The top module holds the register and the FSM.

Test Plan:
- Reset/sequential: rst pulse with RESET_PC = 0, then 3 free-running cycles → pc = 0, 4, 8, 12; PCaddr = 0, 1, 2, 3; state = RUN.
- Branch and jump: pc = 8, branch_taken with imm16 = 16'hFFFE → pc = 4. Next cycle, jump with target26 = 26'd5 → pc = 20 (PCaddr = 5).
- Stall priority: stall and jump together at pc = 12 → pc stays 12. Release stall → pc = 16.
- Fault cases:
  - jr with rs_data = 32'h0000_0006 → FAULT, fault = 1, pc unchanged.
  - Separately, running sequentially from pc = 124 (IM_WORDS = 32) → FAULT.
- Halt then async reset:
  - halt_req at pc = 16 → state = HALT, pc stays 16 for 5 cycles despite jumps.
  - Asserting rst mid-cycle → pc = 0 immediately, state = RUN.
- PC_PERF_CNT_EN: 4 sequential updates, 1 branch, 1 stall cycle → retired_cnt = 5, redirect_cnt = 1.
